// File: rtl/me_pkg.sv
// Shared constants, types and pixel/candidate helpers for the full-search SAD engine.
package me_pkg;
   localparam int BLK   = 16;
   localparam int WIN   = 23;
   localparam int PIX_W = 8;
   localparam int SAD_W = 16;
   localparam int NCAND = 64;
   localparam int NOFF  = 8;

   typedef logic [SAD_W-1:0] sad_t;

   typedef struct packed {
      logic [5:0] idx;
      sad_t       sad;
   } cand_t;

   function automatic logic [PIX_W-1:0] absdiff8(input logic [PIX_W-1:0] a,
                                                 input logic [PIX_W-1:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

   // Inputs are in ascending index order, so strict compares keep the lowest index on ties.
   function automatic cand_t min4(input cand_t a, input cand_t b,
                                  input cand_t c, input cand_t d);
      cand_t m0;
      cand_t m1;
      m0 = (b.sad < a.sad) ? b : a;
      m1 = (d.sad < c.sad) ? d : c;
      return (m1.sad < m0.sad) ? m1 : m0;
   endfunction
endpackage

// File: rtl/me_sad_row16.sv
// One (v,h) row contribution: 16 absolute differences reduced by a balanced adder tree.
module me_sad_row16
   import me_pkg::*;
(
   input  logic [BLK*PIX_W-1:0] ref_seg_i,
   input  logic [BLK*PIX_W-1:0] cur_seg_i,
   output logic [SAD_W-1:0]     sad_o
);
   logic [PIX_W-1:0] d [BLK];
   sad_t l1 [8];
   sad_t l2 [4];
   sad_t l3 [2];

   always_comb begin
      for (int i = 0; i < BLK; i++) begin
         d[i] = absdiff8(ref_seg_i[(BLK-1-i)*PIX_W +: PIX_W],
                         cur_seg_i[(BLK-1-i)*PIX_W +: PIX_W]);
      end
      for (int i = 0; i < 8; i++) l1[i] = sad_t'(d[2*i]) + sad_t'(d[2*i+1]);
      for (int i = 0; i < 4; i++) l2[i] = l1[2*i] + l1[2*i+1];
      for (int i = 0; i < 2; i++) l3[i] = l2[2*i] + l2[2*i+1];
      sad_o = l3[0] + l3[1];
   end
endmodule

// File: rtl/me_sad_engine.sv
// Full-search SAD engine: 64 candidate accumulators fed one reference row per cycle,
// double-buffered current block, snapshot bank and a 3-stage 4:1 minimum tree.
module me_sad_engine
   import me_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic [183:0] ref_row,
   input  logic         ref_valid,
   input  logic         ref_first,
   input  logic [127:0] cur_row,
   input  logic         cur_valid,
   output logic         cur_ready,
   output logic         mv_valid,
   output logic [3:0]   mv_x,
   output logic [3:0]   mv_y,
   output logic [15:0]  min_sad,
   output logic         cur_miss
);
   localparam int         ROW_W    = BLK*PIX_W;
   localparam logic [4:0] LAST_ROW = 5'(WIN-1);

   logic [ROW_W-1:0] bank_q [2][BLK];
   logic             act_sel_q, load_full_q;
   logic [3:0]       cur_wcnt_q;
   logic [4:0]       r_q;
   logic             in_win_q;
   sad_t             acc_q [NOFF][NOFF];
   sad_t             snap_q [NCAND];
   logic             snap_vld_q, s1_vld_q, s2_vld_q, s3_vld_q;
   cand_t            s1_q [16];
   cand_t            s2_q [4];
   cand_t            s3_q;
   logic             mv_valid_q, cur_miss_q;
   logic [3:0]       mv_x_q, mv_y_q;
   sad_t             min_sad_q;

   logic             win_start, row_ok, beat, swap, use_sel, last_row;
   logic [4:0]       r_cur;
   logic [ROW_W-1:0] cur_sel [NOFF];
   logic [NOFF-1:0]  row_en;
   sad_t             contrib [NOFF][NOFF];
   sad_t             sum_d [NOFF][NOFF];
   cand_t            s0 [NCAND];
   cand_t            s1_d [16];
   cand_t            s2_d [4];
   cand_t            s3_d;

   // A window start swaps in the load bank when it is full or is completed by this very beat.
   always_comb begin
      win_start = ref_valid && ref_first;
      row_ok    = ref_valid && (ref_first || in_win_q);
      r_cur     = ref_first ? 5'd0 : r_q;
      last_row  = (r_cur == LAST_ROW);
      beat      = cur_valid && !load_full_q;
      swap      = win_start && (load_full_q || (beat && cur_wcnt_q == 4'(BLK-1)));
      use_sel   = swap ? ~act_sel_q : act_sel_q;
      for (int v = 0; v < NOFF; v++) begin
         row_en[v]  = (r_cur >= 5'(v)) && (r_cur <= 5'(v + BLK - 1));
         cur_sel[v] = bank_q[use_sel][4'(r_cur - 5'(v))];
      end
   end

   for (genvar v = 0; v < NOFF; v++) begin : g_v
      for (genvar h = 0; h < NOFF; h++) begin : g_h
         me_sad_row16 u_row (
            .ref_seg_i (ref_row[(WIN-h)*PIX_W-1 -: ROW_W]),
            .cur_seg_i (cur_sel[v]),
            .sad_o     (contrib[v][h])
         );
      end
   end

   always_comb begin
      for (int v = 0; v < NOFF; v++) begin
         for (int h = 0; h < NOFF; h++) begin
            sum_d[v][h] = ((r_cur == 5'd0) ? sad_t'(0) : acc_q[v][h])
                        + (row_en[v] ? contrib[v][h] : sad_t'(0));
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NCAND; k++) begin
         s0[k].idx = 6'(k);
         s0[k].sad = snap_q[k];
      end
      for (int g = 0; g < 16; g++) s1_d[g] = min4(s0[4*g], s0[4*g+1], s0[4*g+2], s0[4*g+3]);
      for (int g = 0; g < 4; g++)  s2_d[g] = min4(s1_q[4*g], s1_q[4*g+1], s1_q[4*g+2], s1_q[4*g+3]);
      s3_d = min4(s2_q[0], s2_q[1], s2_q[2], s2_q[3]);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         act_sel_q   <= 1'b0;
         load_full_q <= 1'b0;
         cur_wcnt_q  <= 4'd0;
         r_q         <= 5'd0;
         in_win_q    <= 1'b0;
         snap_vld_q  <= 1'b0;
         s1_vld_q    <= 1'b0;
         s2_vld_q    <= 1'b0;
         s3_vld_q    <= 1'b0;
         mv_valid_q  <= 1'b0;
         cur_miss_q  <= 1'b0;
         mv_x_q      <= 4'd0;
         mv_y_q      <= 4'd0;
         min_sad_q   <= '0;
      end else begin
         if (swap) begin
            act_sel_q   <= ~act_sel_q;
            load_full_q <= 1'b0;
            cur_wcnt_q  <= 4'd0;
         end else if (beat) begin
            cur_wcnt_q <= cur_wcnt_q + 4'd1;
            if (cur_wcnt_q == 4'(BLK-1)) load_full_q <= 1'b1;
         end
         cur_miss_q <= win_start && !swap;
         if (row_ok) begin
            in_win_q <= !last_row;
            r_q      <= last_row ? r_cur : r_cur + 5'd1;
         end
         snap_vld_q <= row_ok && last_row;
         s1_vld_q   <= snap_vld_q;
         s2_vld_q   <= s1_vld_q;
         s3_vld_q   <= s2_vld_q;
         mv_valid_q <= s3_vld_q;
         if (s3_vld_q) begin
            mv_x_q    <= {1'b0, s3_q.idx[2:0]} - 4'd4;
            mv_y_q    <= {1'b0, s3_q.idx[5:3]} - 4'd4;
            min_sad_q <= s3_q.sad;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         acc_q <= '{default: '0};
      end else if (row_ok && !last_row) begin
         acc_q <= sum_d;
      end
   end

   // Final row lands in the snapshot so the next window's row 0 can reuse acc immediately.
   always_ff @(posedge clk) begin
      if (row_ok && last_row) begin
         for (int k = 0; k < NCAND; k++) snap_q[k] <= sum_d[k/NOFF][k%NOFF];
      end
      if (beat) bank_q[~act_sel_q][cur_wcnt_q] <= cur_row;
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
   end

   assign cur_ready = !load_full_q;
   assign mv_valid  = mv_valid_q;
   assign mv_x      = mv_x_q;
   assign mv_y      = mv_y_q;
   assign min_sad   = min_sad_q;
   assign cur_miss  = cur_miss_q;
endmodule

// File: tb/tb_me_sad_engine.sv
// Self-checking bench for me_sad_engine against a direct full-search SAD model.
module tb_me_sad_engine;
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [183:0] ref_row = '0;
   logic         ref_valid = 1'b0;
   logic         ref_first = 1'b0;
   logic [127:0] cur_row = '0;
   logic         cur_valid = 1'b0;
   logic         cur_ready, mv_valid, cur_miss;
   logic [3:0]   mv_x, mv_y;
   logic [15:0]  min_sad;

   me_sad_engine dut (
      .clk(clk), .rst(rst), .ref_row(ref_row), .ref_valid(ref_valid), .ref_first(ref_first),
      .cur_row(cur_row), .cur_valid(cur_valid), .cur_ready(cur_ready), .mv_valid(mv_valid),
      .mv_x(mv_x), .mv_y(mv_y), .min_sad(min_sad), .cur_miss(cur_miss)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      int          stamp;
      logic [3:0]  x;
      logic [3:0]  y;
      logic [15:0] sad;
   } res_t;

   res_t got_q[$];
   res_t exp_q[$];
   int   got_miss[$];
   int   exp_miss[$];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   win [23][23];
   int   nxt [16][16];
   int   pend [16][16];
   int   act [16][16];
   bit   pend_full = 0;
   res_t mon_r;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mv_valid === 1'b1) begin
         mon_r.stamp = cyc;
         mon_r.x = mv_x;
         mon_r.y = mv_y;
         mon_r.sad = min_sad;
         got_q.push_back(mon_r);
      end
      if (cur_miss === 1'b1) got_miss.push_back(cyc);
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Exhaustive search over the 8x8 offsets; strict less keeps the lowest index on ties.
   function automatic res_t model(input int stamp);
      res_t r;
      int best = -1;
      int bk = 0;
      for (int k = 0; k < 64; k++) begin
         int s = 0;
         for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) begin
               int d = win[k/8 + y][k%8 + x] - act[y][x];
               s += (d < 0) ? -d : d;
            end
         if (best < 0 || s < best) begin
            best = s;
            bk = k;
         end
      end
      r.stamp = stamp;
      r.x = 4'(bk % 8 - 4);
      r.y = 4'(bk / 8 - 4);
      r.sad = 16'(best);
      return r;
   endfunction

   function automatic logic [183:0] ref_vec(input int r);
      logic [183:0] v;
      for (int p = 0; p < 23; p++) v[183-8*p -: 8] = 8'(win[r][p]);
      return v;
   endfunction

   function automatic logic [127:0] cur_vec(input int y);
      logic [127:0] v;
      for (int p = 0; p < 16; p++) v[127-8*p -: 8] = 8'(nxt[y][p]);
      return v;
   endfunction

   task automatic clear_q();
      got_q.delete(); exp_q.delete(); got_miss.delete(); exp_miss.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic load_cur(input int n);
      for (int b = 0; b < n; b++) begin
         int t = 0;
         cur_row = cur_vec(b);
         cur_valid = 1'b1;
         while (cur_ready !== 1'b1 && t < 64) begin @(posedge clk); #1; t++; end
         if (t >= 64) begin
            n_tests++; n_fail++;
            $display("FAIL load_ready_timeout: cur_ready=%b after %0d cycles, want 1", cur_ready, t);
         end
         @(posedge clk); #1;
      end
      cur_valid = 1'b0;
      if (n == 16) begin pend = nxt; pend_full = 1; end
   endtask

   task automatic run_window(input int nrows, input bit gaps, input bit beat15);
      int e22 = 0;
      for (int r = 0; r < nrows; r++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            ref_valid = 1'b0; ref_first = 1'b0;
            idle($urandom_range(1, 3));
         end
         ref_row = ref_vec(r);
         ref_valid = 1'b1;
         ref_first = (r == 0);
         if (r == 0 && beat15) begin cur_row = cur_vec(15); cur_valid = 1'b1; end
         @(posedge clk); #1;
         if (r == 0) begin
            if (beat15) begin act = nxt; pend_full = 0; cur_valid = 1'b0; end
            else if (pend_full) begin act = pend; pend_full = 0; end
            else exp_miss.push_back(cyc);
         end
         if (r == 22) e22 = cyc;
      end
      ref_valid = 1'b0;
      ref_first = 1'b0;
      if (nrows == 23) exp_q.push_back(model(e22 + 4));
   endtask

   task automatic rand_win();
      for (int r = 0; r < 23; r++) for (int c = 0; c < 23; c++) win[r][c] = $urandom_range(0, 255);
   endtask

   task automatic rand_nxt();
      for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) nxt[r][c] = $urandom_range(0, 255);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle(3);
      n_tests++; if (cur_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cur_ready: got %b want 1", cur_ready); end
      n_tests++; if (mv_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mv_valid: got %b want 0", mv_valid); end
      n_tests++; if (mv_x !== 4'd0 || mv_y !== 4'd0) begin n_fail++; $display("FAIL reset_mv: got %h/%h want 0/0", mv_x, mv_y); end
      n_tests++; if (min_sad !== 16'd0) begin n_fail++; $display("FAIL reset_min_sad: got %0d want 0", min_sad); end
      n_tests++; if (cur_miss !== 1'b0) begin n_fail++; $display("FAIL reset_cur_miss: got %b want 0", cur_miss); end
      rst = 1'b1;
      pend_full = 0;
      idle(1);
   endtask

   task automatic test_identical();
      res_t e, g;
      clear_q();
      for (int r = 0; r < 23; r++)
         for (int c = 0; c < 23; c++)
            win[r][c] = (r < 4 || r > 19 || c < 4 || c > 19) ? 0 : 'h40;
      for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) nxt[r][c] = 'h40;
      load_cur(16);
      n_tests++; if (cur_ready !== 1'b0) begin n_fail++; $display("FAIL identical_full_ready: got %b want 0", cur_ready); end
      run_window(23, 0, 0);
      idle(8);
      n_tests++; if (got_q.size() != exp_q.size() || got_miss.size() != 0) begin
         n_fail++; $display("FAIL identical_count: got %0d results %0d misses, want %0d results 0 misses", got_q.size(), got_miss.size(), exp_q.size());
      end else while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
         if (g !== e) begin n_fail++; $display("FAIL identical_result: got @%0d (%0d,%0d) sad %0d, want @%0d (%0d,%0d) sad %0d", g.stamp, $signed(g.x), $signed(g.y), g.sad, e.stamp, $signed(e.x), $signed(e.y), e.sad); end
      end
   endtask

   task automatic test_shifted();
      res_t e, g;
      clear_q();
      rand_win();
      for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) nxt[y][x] = win[1+y][6+x];
      load_cur(16);
      run_window(23, 0, 0);
      idle(8);
      n_tests++; if (got_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL shifted_count: got %0d want %0d", got_q.size(), exp_q.size());
      end else while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
         if (g !== e) begin n_fail++; $display("FAIL shifted_result: got @%0d (%0d,%0d) sad %0d, want @%0d (%0d,%0d) sad %0d", g.stamp, $signed(g.x), $signed(g.y), g.sad, e.stamp, $signed(e.x), $signed(e.y), e.sad); end
      end
   endtask

   task automatic test_ties();
      res_t e, g;
      clear_q();
      for (int r = 0; r < 23; r++) for (int c = 0; c < 23; c++) win[r][c] = 0;
      for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) nxt[r][c] = 0;
      load_cur(16);
      run_window(23, 0, 0);
      idle(8);
      n_tests++; if (got_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL ties_count: got %0d want %0d", got_q.size(), exp_q.size());
      end else while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
         if (g !== e) begin n_fail++; $display("FAIL ties_result: got @%0d (%0d,%0d) sad %0d, want @%0d (%0d,%0d) sad %0d", g.stamp, $signed(g.x), $signed(g.y), g.sad, e.stamp, $signed(e.x), $signed(e.y), e.sad); end
      end
   endtask

   task automatic test_max();
      res_t e, g;
      clear_q();
      for (int r = 0; r < 23; r++) for (int c = 0; c < 23; c++) win[r][c] = 0;
      for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) nxt[r][c] = 255;
      load_cur(16);
      run_window(23, 0, 0);
      idle(8);
      n_tests++; if (got_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL max_count: got %0d want %0d", got_q.size(), exp_q.size());
      end else while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
         if (g !== e) begin n_fail++; $display("FAIL max_result: got @%0d (%0d,%0d) sad %0d, want @%0d (%0d,%0d) sad %0d", g.stamp, $signed(g.x), $signed(g.y), g.sad, e.stamp, $signed(e.x), $signed(e.y), e.sad); end
      end
   endtask

   task automatic test_swap_coincide();
      res_t e, g;
      clear_q();
      rand_nxt();
      rand_win();
      load_cur(15);
      run_window(23, 0, 1);
      idle(8);
      n_tests++; if (got_q.size() != exp_q.size() || got_miss.size() != 0) begin
         n_fail++; $display("FAIL coincide_count: got %0d results %0d misses, want %0d results 0 misses", got_q.size(), got_miss.size(), exp_q.size());
      end else while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
         if (g !== e) begin n_fail++; $display("FAIL coincide_result: got @%0d (%0d,%0d) sad %0d, want @%0d (%0d,%0d) sad %0d", g.stamp, $signed(g.x), $signed(g.y), g.sad, e.stamp, $signed(e.x), $signed(e.y), e.sad); end
      end
   endtask

   task automatic test_back_to_back();
      res_t e, g;
      clear_q();
      rand_nxt();
      load_cur(16);
      rand_win();
      rand_nxt();
      fork
         run_window(23, 0, 0);
         load_cur(16);
      join
      rand_win();
      run_window(23, 0, 0);
      rand_win();
      run_window(23, 0, 0);
      idle(8);
      n_tests++; if (got_miss.size() != exp_miss.size() || (exp_miss.size() == 1 && got_miss[0] != exp_miss[0])) begin
         n_fail++; $display("FAIL b2b_miss: got %0d pulses (first @%0d), want %0d (@%0d)", got_miss.size(), (got_miss.size() > 0) ? got_miss[0] : -1, exp_miss.size(), (exp_miss.size() > 0) ? exp_miss[0] : -1);
      end
      n_tests++; if (got_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size());
      end else while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
         if (g !== e) begin n_fail++; $display("FAIL b2b_result: got @%0d (%0d,%0d) sad %0d, want @%0d (%0d,%0d) sad %0d", g.stamp, $signed(g.x), $signed(g.y), g.sad, e.stamp, $signed(e.x), $signed(e.y), e.sad); end
      end
   endtask

   task automatic test_gaps();
      res_t e, g;
      clear_q();
      rand_nxt();
      rand_win();
      load_cur(16);
      run_window(23, 1, 0);
      ref_row = ref_vec(5);
      ref_valid = 1'b1;
      ref_first = 1'b0;
      @(posedge clk); #1;
      ref_valid = 1'b0;
      idle(8);
      n_tests++; if (got_q.size() != exp_q.size() || got_miss.size() != 0) begin
         n_fail++; $display("FAIL gaps_count: got %0d results %0d misses, want %0d results 0 misses", got_q.size(), got_miss.size(), exp_q.size());
      end else while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
         if (g !== e) begin n_fail++; $display("FAIL gaps_result: got @%0d (%0d,%0d) sad %0d, want @%0d (%0d,%0d) sad %0d", g.stamp, $signed(g.x), $signed(g.y), g.sad, e.stamp, $signed(e.x), $signed(e.y), e.sad); end
      end
   endtask

   task automatic test_abort();
      res_t e, g;
      clear_q();
      rand_nxt();
      rand_win();
      load_cur(16);
      run_window(6, 0, 0);
      rand_win();
      run_window(23, 0, 0);
      idle(8);
      n_tests++; if (got_miss.size() != exp_miss.size() || (exp_miss.size() == 1 && got_miss[0] != exp_miss[0])) begin
         n_fail++; $display("FAIL abort_miss: got %0d pulses, want %0d", got_miss.size(), exp_miss.size());
      end
      n_tests++; if (got_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL abort_count: got %0d want %0d", got_q.size(), exp_q.size());
      end else while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
         if (g !== e) begin n_fail++; $display("FAIL abort_result: got @%0d (%0d,%0d) sad %0d, want @%0d (%0d,%0d) sad %0d", g.stamp, $signed(g.x), $signed(g.y), g.sad, e.stamp, $signed(e.x), $signed(e.y), e.sad); end
      end
   endtask

   task automatic test_reset_mid();
      res_t e, g;
      clear_q();
      rand_nxt();
      rand_win();
      load_cur(16);
      run_window(10, 0, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      pend_full = 0;
      n_tests++; if (cur_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_cur_ready: got %b want 1", cur_ready); end
      idle(10);
      n_tests++; if (got_q.size() != 0) begin n_fail++; $display("FAIL rstmid_no_result: got %0d results want 0", got_q.size()); end
      clear_q();
      rand_nxt();
      rand_win();
      load_cur(16);
      run_window(23, 0, 0);
      idle(8);
      n_tests++; if (got_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL rstmid_count: got %0d want %0d", got_q.size(), exp_q.size());
      end else while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
         if (g !== e) begin n_fail++; $display("FAIL rstmid_result: got @%0d (%0d,%0d) sad %0d, want @%0d (%0d,%0d) sad %0d", g.stamp, $signed(g.x), $signed(g.y), g.sad, e.stamp, $signed(e.x), $signed(e.y), e.sad); end
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_identical();
      test_shifted();
      test_ties();
      test_max();
      test_swap_coincide();
      test_back_to_back();
      test_gaps();
      test_abort();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
